// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and sizing helper for the bit-serial adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width: $clog2(WIDTH), never narrower than one bit
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic carry_in_i,
   output logic sum_o,
   output logic carry_out_o
);

   assign sum_o       = a_i ^ b_i ^ carry_in_i;
   assign carry_out_o = (a_i & b_i) | (carry_in_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder sequencing one bit pair per cycle through full_adder
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o
);

   localparam int CW = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_sum_o;
   logic [WIDTH-1:0] w_sum_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic             w_accept;

   full_adder u_fa (
      .a_i        (r_a[0]),
      .b_i        (r_b[0]),
      .carry_in_i (r_carry),
      .sum_o      (w_s),
      .carry_out_o(w_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts the LSB-first stream lines up
   assign w_sum_nxt = WIDTH'({w_s, r_sum} >> 1);
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign w_accept  = start_i && (r_state != RUN);

   // Next state: RUN ends on the terminal count, start is honoured only outside RUN
   always_comb begin
      w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (w_accept ? RUN : IDLE);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Operand capture, serial datapath and result registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_sum_o <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_i;
         r_b     <= b_i;
         r_carry <= carry_in_i;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_sum   <= w_sum_nxt;
         r_carry <= w_c;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum_o <= w_sum_nxt;
            r_cout  <= w_c;
         end
      end
   end

   assign busy_o      = (r_state == RUN);
   assign done_o      = (r_state == DONE);
   assign sum_o       = r_sum_o;
   assign carry_out_o = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .a_i        (a),
      .b_i        (b),
      .carry_in_i (cin),
      .busy_o     (busy),
      .done_o     (done),
      .sum_o      (sum),
      .carry_out_o(cout)
   );

   always #5 clk = ~clk;

   // Reference: (W+1)-bit sum of the operands and carry-in
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // One operation from IDLE: start for one cycle, observe busy cycles, done timing and sum hold
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output int busy_cnt, output int done_at, output logic held);
      logic [W-1:0] s0;
      busy_cnt = 0;
      done_at  = -1;
      held     = 1'b1;
      @(negedge clk);
      s0 = sum;
      start = 1'b1; a = x; b = y; cin = c;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (busy) begin
            busy_cnt++;
            if (sum !== s0) held = 1'b0;
         end
         if (done) begin
            done_at = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
      n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] xs[4] = '{8'h00, 8'h3C, 8'hFF, 8'hA5};
      logic [W-1:0] ys[4] = '{8'h00, 8'h0F, 8'h01, 8'h5A};
      logic         cs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int bc, da;
      logic held;
      logic [W:0] exp;
      for (int i = 0; i < 4; i++) begin
         run_op(xs[i], ys[i], cs[i], bc, da, held);
         exp = model(xs[i], ys[i], cs[i]);
         n_tests++; if (bc !== W) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, W); end
         n_tests++; if (da !== W + 1) begin n_fail++; $display("FAIL dir%0d_done_latency got %0d want %0d", i, da, W + 1); end
         n_tests++; if ({cout, sum} !== exp) begin n_fail++; $display("FAIL dir%0d_result got %b/%h want %b/%h", i, cout, sum, exp[W], exp[W-1:0]); end
         if (i == 2) begin
            n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL dir2_sum_hold got changed want held 4b"); end
         end
      end
   endtask

   task automatic test_random();
      int bc, da;
      logic held;
      logic [W-1:0] x, y;
      logic c;
      logic [W:0] exp;
      for (int i = 0; i < 20; i++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         run_op(x, y, c, bc, da, held);
         exp = model(x, y, c);
         n_tests++; if (da !== W + 1) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, da, W + 1); end
         n_tests++; if ({cout, sum} !== exp) begin n_fail++; $display("FAIL rnd%0d_result %h+%h+%b got %b/%h want %b/%h", i, x, y, c, cout, sum, exp[W], exp[W-1:0]); end
      end
   endtask

   task automatic test_ignore_start();
      int pulses = 0;
      logic [W:0] exp = model(8'h3C, 8'h0F, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         start = (n >= 2 && n <= 4);
         if (n == 2) begin a = 8'h01; b = 8'h01; end
         if (done) pulses++;
      end
      n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d want 1", pulses); end
      n_tests++; if ({cout, sum} !== exp) begin n_fail++; $display("FAIL ignore_result got %b/%h want %b/%h", cout, sum, exp[W], exp[W-1:0]); end
   endtask

   task automatic test_back_to_back();
      int d[2] = '{-1, -1};
      int k = 0;
      logic [W-1:0] s[2];
      logic c[2];
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      for (int n = 1; n <= 40 && k < 2; n++) begin
         @(negedge clk);
         if (n == 1) begin a = 8'h80; b = 8'h80; end
         if (done) begin d[k] = n; s[k] = sum; c[k] = cout; k++; end
      end
      start = 1'b0;
      n_tests++; if (k !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", k); end
      if (k == 2) begin
         n_tests++; if (d[1] - d[0] !== W + 1) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", d[1] - d[0], W + 1); end
         n_tests++; if ({c[0], s[0]} !== model(8'h10, 8'h20, 1'b0)) begin n_fail++; $display("FAIL b2b_first got %b/%h want 0/30", c[0], s[0]); end
         n_tests++; if ({c[1], s[1]} !== model(8'h80, 8'h80, 1'b0)) begin n_fail++; $display("FAIL b2b_second got %b/%h want 1/00", c[1], s[1]); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      int bc, da;
      logic held;
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
      n_tests++; if ({cout, sum} !== '0) begin n_fail++; $display("FAIL midrst_outputs got %b/%h want 0/00", cout, sum); end
      rst_n = 1'b1;
      run_op(8'h01, 8'h02, 1'b0, bc, da, held);
      n_tests++; if (da !== W + 1) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", da, W + 1); end
      n_tests++; if ({cout, sum} !== model(8'h01, 8'h02, 1'b0)) begin n_fail++; $display("FAIL midrst_result got %b/%h want 0/03", cout, sum); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
